// File: rtl/nf_ahb_pwm_mc.sv
`default_nettype none
// ============================================================================
// Module  : nf_ahb_pwm_mc
// Brief   : Multi-channel AHB-Lite PWM slave, shared prescaler/period counter,
//           shadow/active compare registers and sticky period-wrap interrupt.
// Rev     : 1.0
// ============================================================================
module nf_ahb_pwm_mc #(
    parameter int CH_N  = 4,
    parameter int PWM_W = 16,
    parameter int PRE_W = 16
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic [31:0]      haddr_s,
    input  logic [31:0]      hwdata_s,
    output logic [31:0]      hrdata_s,
    input  logic             hwrite_s,
    input  logic [1:0]       htrans_s,
    input  logic [2:0]       hsize_s,
    input  logic [2:0]       hburst_s,
    output logic [1:0]       hresp_s,
    output logic             hready_s,
    input  logic             hsel_s,
    output logic [CH_N-1:0]  pwm,
    output logic             irq
);
    localparam logic [5:0]       c_addr_ctrl   = 6'd0;
    localparam logic [5:0]       c_addr_presc  = 6'd1;
    localparam logic [5:0]       c_addr_period = 6'd2;
    localparam logic [5:0]       c_addr_status = 6'd3;
    localparam logic [5:0]       c_addr_cmp0   = 6'd4;
    localparam logic [PWM_W-1:0] c_cnt_one     = 1;
    localparam logic [PRE_W-1:0] c_presc_one   = 1;

    logic             r_dph_valid;
    logic             r_dph_write;
    logic [5:0]       r_dph_addr;
    logic             r_en;
    logic             r_sync_upd;
    logic             r_irq_en;
    logic [PRE_W-1:0] r_presc;
    logic [PRE_W-1:0] r_presc_cnt;
    logic [PWM_W-1:0] r_period_sh;
    logic [PWM_W-1:0] r_period_act;
    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_cmp_sh  [CH_N];
    logic [PWM_W-1:0] r_cmp_act [CH_N];
    logic [CH_N-1:0]  r_pwm;
    logic             r_flag;
    logic             r_irq;

    logic             w_accept;
    logic             w_wr;
    logic             w_tick;
    logic             w_wrap;
    logic             w_copy;
    logic             w_w1c;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign hready_s = 1'b1;
    assign hresp_s  = 2'b00;
    assign hrdata_s = w_rdata;
    assign pwm      = r_pwm;
    assign irq      = r_irq;

    assign w_accept = hsel_s & htrans_s[1] & hready_s;
    assign w_wr     = r_dph_valid & r_dph_write;
    assign w_tick   = r_en & (r_presc_cnt == r_presc);
    assign w_wrap   = w_tick & (r_cnt == r_period_act);
    // Shadows track continuously unless synchronous update is armed while running.
    assign w_copy   = ~r_en | ~r_sync_upd | w_wrap;
    assign w_w1c    = w_wr & (r_dph_addr == c_addr_status) & hwdata_s[0];
    assign w_unused = ^{haddr_s, hsize_s, hburst_s, htrans_s[0], hwdata_s};

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_dph_valid <= 1'b0;
            r_dph_write <= 1'b0;
            r_dph_addr  <= '0;
        end else begin
            r_dph_valid <= w_accept;
            if (w_accept) begin
                r_dph_write <= hwrite_s;
                r_dph_addr  <= haddr_s[7:2];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_en        <= 1'b0;
            r_sync_upd  <= 1'b0;
            r_irq_en    <= 1'b0;
            r_presc     <= '0;
            r_period_sh <= '0;
        end else if (w_wr) begin
            case (r_dph_addr)
                c_addr_ctrl:   {r_irq_en, r_sync_upd, r_en} <= hwdata_s[2:0];
                c_addr_presc:  r_presc     <= hwdata_s[PRE_W-1:0];
                c_addr_period: r_period_sh <= hwdata_s[PWM_W-1:0];
                default:       ;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        for (int i = 0; i < CH_N; i++) begin
            if (hreset) begin
                r_cmp_sh[i]  <= '0;
                r_cmp_act[i] <= '0;
                r_pwm[i]     <= 1'b0;
            end else begin
                if (w_wr && (r_dph_addr == c_addr_cmp0 + 6'(i)))
                    r_cmp_sh[i] <= hwdata_s[PWM_W-1:0];
                if (w_copy)
                    r_cmp_act[i] <= r_cmp_sh[i];
                r_pwm[i] <= r_en & (r_cnt < r_cmp_act[i]);
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_presc_cnt  <= '0;
            r_cnt        <= '0;
            r_period_act <= '0;
            r_flag       <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_copy)
                r_period_act <= r_period_sh;
            if (!r_en) begin
                r_presc_cnt <= '0;
                r_cnt       <= '0;
            end else if (w_tick) begin
                r_presc_cnt <= '0;
                // A period shrunk below cnt lets cnt roll over naturally, without a wrap.
                r_cnt       <= w_wrap ? '0 : r_cnt + c_cnt_one;
            end else begin
                r_presc_cnt <= r_presc_cnt + c_presc_one;
            end
            r_flag <= w_wrap | (r_flag & ~w_w1c);
            r_irq  <= r_flag & r_irq_en;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (r_dph_valid && !r_dph_write) begin
            case (r_dph_addr)
                c_addr_ctrl:   w_rdata[2:0]       = {r_irq_en, r_sync_upd, r_en};
                c_addr_presc:  w_rdata[PRE_W-1:0] = r_presc;
                c_addr_period: w_rdata[PWM_W-1:0] = r_period_sh;
                c_addr_status: w_rdata[0]         = r_flag;
                default: begin
                    for (int i = 0; i < CH_N; i++) begin
                        if (r_dph_addr == c_addr_cmp0 + 6'(i))
                            w_rdata[PWM_W-1:0] = r_cmp_sh[i];
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nf_ahb_pwm_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_nf_ahb_pwm_mc
// Brief   : Self-checking bench for nf_ahb_pwm_mc (register vectors + PWM timing).
// Rev     : 1.0
// ============================================================================
module tb_nf_ahb_pwm_mc;
    localparam int         CH_N     = 4;
    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_PRESC  = 8'h04;
    localparam logic [7:0] A_PERIOD = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h0C;
    localparam logic [7:0] A_CMP0   = 8'h10;

    logic            hclk = 1'b0;
    logic            hreset = 1'b1;
    logic [31:0]     haddr_s = '0;
    logic [31:0]     hwdata_s = '0;
    logic [31:0]     hrdata_s;
    logic            hwrite_s = 1'b0;
    logic [1:0]      htrans_s = 2'b00;
    logic [2:0]      hsize_s = 3'b010;
    logic [2:0]      hburst_s = 3'b000;
    logic [1:0]      hresp_s;
    logic            hready_s;
    logic            hsel_s = 1'b0;
    logic [CH_N-1:0] pwm;
    logic            irq;

    nf_ahb_pwm_mc #(.CH_N(CH_N), .PWM_W(16), .PRE_W(16)) dut (
        .hclk(hclk), .hreset(hreset), .haddr_s(haddr_s), .hwdata_s(hwdata_s),
        .hrdata_s(hrdata_s), .hwrite_s(hwrite_s), .htrans_s(htrans_s),
        .hsize_s(hsize_s), .hburst_s(hburst_s), .hresp_s(hresp_s),
        .hready_s(hready_s), .hsel_s(hsel_s), .pwm(pwm), .irq(irq)
    );

    always #5 hclk = ~hclk;

    typedef struct { string name; logic [31:0] exp; } sb_t;
    typedef struct { logic [7:0] addr; logic [31:0] wdata; logic [31:0] exp; string name; } vec_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         c_old;
    int         c_new;
    int         cnt_hi;
    sb_t        sb_q [$];
    sb_t        sb_e;
    logic       rd_dph = 1'b0;
    vec_t       vecs [8];
    logic [7:0] rd_offs [9];

    always @(posedge hclk) cyc <= cyc + 1;
    always @(posedge hclk) rd_dph <= !hreset && hsel_s && htrans_s[1] && !hwrite_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: read data phases pop the value pushed when the address phase was driven.
    always @(negedge hclk) begin
        if (rd_dph) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got 0x%08h, expected no read", hrdata_s);
            end else begin
                sb_e = sb_q.pop_front();
                check(sb_e.name, hrdata_s, sb_e.exp);
            end
        end
    end

    task automatic idle();
        hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; haddr_s = '0;
    endtask

    task automatic sync_drv();
        @(posedge hclk); #1;
    endtask

    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = {24'h0, a};
        sync_drv();
        idle();
        hwdata_s = d;
        sync_drv();
    endtask

    task automatic ahb_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b0; haddr_s = {24'h0, a};
        sync_drv();
        idle();
        sync_drv();
    endtask

    task automatic set_vec(input int i, input logic [7:0] a, input logic [31:0] w,
                           input logic [31:0] e, input string n);
        vecs[i].addr = a; vecs[i].wdata = w; vecs[i].exp = e; vecs[i].name = n;
    endtask

    task automatic count_high(input int ch, input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge hclk);
            if (pwm[ch]) c++;
        end
    endtask

    // which: 0 = pwm[0], 1 = irq; always ends on a negedge.
    task automatic wait_sig(input int which, input logic v, input string name);
        int k;
        k = 0;
        @(negedge hclk);
        while (((which == 0) ? pwm[0] : irq) !== v && k < 200) begin
            @(negedge hclk);
            k++;
        end
        if (((which == 0) ? pwm[0] : irq) !== v) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_wait: got timeout, expected level %0b", name, v);
        end
    endtask

    // A pwm[0] rise marks the cycle after a wrap; the next irq rise is one period later.
    task automatic measure_wrap(input int exp_cyc, input string name);
        int t0;
        for (int k = 0; k < 2; k++) begin
            wait_sig(0, 1'b0, name);
            wait_sig(0, 1'b1, name);
            t0 = cyc;
            sync_drv();
            ahb_write(A_STATUS, 32'h1);
            @(posedge hclk);
            @(negedge hclk);
            check({name, "_irq_clr"}, 32'(irq), 32'd0);
            wait_sig(1, 1'b1, name);
            check({name, "_interval"}, 32'(cyc - t0), 32'(exp_cyc));
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 9; i++)
            ahb_read(rd_offs[i], 32'h0, $sformatf("%s_rd_%02h", tag, rd_offs[i]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'hFC};
        set_vec(0, A_PRESC,  32'hFFFF_FFFF, 32'h0000_FFFF, "presc_mask");
        set_vec(1, A_PERIOD, 32'h1234_5678, 32'h0000_5678, "period_mask");
        set_vec(2, A_CMP0,   32'h0000_ABCD, 32'h0000_ABCD, "cmp0_rw");
        set_vec(3, 8'h1C,    32'h0001_0007, 32'h0000_0007, "cmp3_mask");
        set_vec(4, 8'h20,    32'h0000_1234, 32'h0000_0000, "unmapped_20");
        set_vec(5, 8'hFC,    32'hFFFF_FFFF, 32'h0000_0000, "unmapped_fc_wr");
        set_vec(6, A_CTRL,   32'hFFFF_FFFE, 32'h0000_0006, "ctrl_mask");
        set_vec(7, A_STATUS, 32'h0000_0001, 32'h0000_0000, "status_w1c_idle");

        // Reset state
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_hready", 32'(hready_s), 32'd1);
        check("rst_hresp", 32'(hresp_s), 32'd0);
        check("rst_hrdata", hrdata_s, 32'd0);
        sync_drv();
        read_all_zero("rst");

        // Register vectors
        for (int i = 0; i < 8; i++) begin
            ahb_write(vecs[i].addr, vecs[i].wdata);
            ahb_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        ahb_write(A_CTRL, 0); ahb_write(A_PRESC, 0); ahb_write(A_PERIOD, 0);
        ahb_write(A_CMP0, 0); ahb_write(8'h1C, 0);

        // PRESC=0 PERIOD=9 CMP0=3: 3 of 10 high, wrap every 10 cycles
        ahb_write(A_PERIOD, 9); ahb_write(A_CMP0, 3); ahb_write(A_CTRL, 5);
        repeat (15) @(posedge hclk);
        count_high(0, 30, cnt_hi); check("duty_3_of_10", 32'(cnt_hi), 32'd9);
        count_high(3, 30, cnt_hi); check("cmp3_zero_low", 32'(cnt_hi), 32'd0);
        measure_wrap(10, "wrap10");

        // PRESC=3 PERIOD=4: CMP1=5 high, CMP2=0 low, CMP0=3 -> 12 of 20
        sync_drv();
        ahb_write(A_CTRL, 0); ahb_write(A_PRESC, 3); ahb_write(A_PERIOD, 4);
        ahb_write(A_CMP0 + 8'h4, 5); ahb_write(A_CMP0 + 8'h8, 0); ahb_write(A_CTRL, 5);
        repeat (30) @(posedge hclk);
        count_high(1, 40, cnt_hi); check("cmp_gt_period_high", 32'(cnt_hi), 32'd40);
        count_high(2, 40, cnt_hi); check("cmp_zero_low", 32'(cnt_hi), 32'd0);
        count_high(0, 40, cnt_hi); check("presc_duty", 32'(cnt_hi), 32'd24);
        measure_wrap(20, "wrap20");

        // Synchronous update: CMP0 3 -> 7 mid-period takes effect after the wrap
        sync_drv();
        ahb_write(A_CTRL, 0); ahb_write(A_PRESC, 0); ahb_write(A_PERIOD, 9);
        ahb_write(A_CMP0, 3); ahb_write(A_CTRL, 7);
        repeat (15) @(posedge hclk);
        wait_sig(0, 1'b0, "sync_align");
        wait_sig(0, 1'b1, "sync_align");
        c_old = 0;
        c_new = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    if (pwm[0]) begin
                        if (i < 10) c_old++;
                        else        c_new++;
                    end
                    @(negedge hclk);
                end
            end
            begin
                sync_drv();
                ahb_write(A_CMP0, 7);
                ahb_read(A_CMP0, 32'h7, "cmp0_shadow_readback");
            end
        join
        check("sync_old_duty", 32'(c_old), 32'd3);
        check("sync_new_duty", 32'(c_new), 32'd7);

        // W1C landing on the same edge as a wrap keeps the flag set
        wait_sig(0, 1'b0, "w1c_align");
        wait_sig(0, 1'b1, "w1c_align");
        repeat (7) @(posedge hclk);
        #1;
        ahb_write(A_STATUS, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            check($sformatf("irq_hold_%0d", i), 32'(irq), 32'd1);
        end
        sync_drv();
        ahb_read(A_STATUS, 32'h1, "status_after_race");

        // Back-to-back write/read of PERIOD, unmapped read
        ahb_write(A_CTRL, 0);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = {24'h0, A_PERIOD};
        sync_drv();
        sb_e.name = "b2b_period";
        sb_e.exp  = 32'h55;
        sb_q.push_back(sb_e);
        hwdata_s = 32'h55; hwrite_s = 1'b0;
        sync_drv();
        idle();
        sync_drv();
        ahb_read(8'hFC, 32'h0, "unmapped_fc_rd");
        check("hready_high", 32'(hready_s), 32'd1);
        check("hresp_okay", 32'(hresp_s), 32'd0);

        // Reset mid-period
        ahb_write(A_PERIOD, 9); ahb_write(A_CMP0, 5); ahb_write(A_CTRL, 5);
        repeat (25) @(posedge hclk);
        wait_sig(0, 1'b0, "rst_align");
        wait_sig(0, 1'b1, "rst_align");
        hreset = 1'b1;
        @(posedge hclk);
        @(negedge hclk);
        check("midrst_pwm", 32'(pwm), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_cnt", 32'(dut.r_cnt), 32'd0);
        sync_drv();
        hreset = 1'b0;
        read_all_zero("midrst");

        repeat (3) @(posedge hclk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nf_ahb_pwm_mc.md
Name: nf_ahb_pwm_mc

Overview:
Multi-channel AHB-Lite PWM slave and the parametrised successor of the single-channel PWM peripheral on the system AHB interconnect. It has one shared prescaler and period counter, per-channel compare registers with shadow/active double-buffering, and a sticky period-wrap flag with an interrupt. Everything runs in the AHB clock domain; there is no separate PWM clock.

Parameters:
ch_n, 4, number of PWM channels (1..16)
pwm_w, 16, width of the period counter and compare registers (2..32)
pre_w, 16, width of the prescaler register (1..32)

Ports:
hclk  in  1  system/AHB clock
hreset  in  1  reset, synchronous, active-high
haddr_s  in  32  AHB HADDR
hwdata_s  in  32  AHB HWDATA
hrdata_s  out  32  AHB HRDATA
hwrite_s  in  1  AHB HWRITE
htrans_s  in  2  AHB HTRANS
hsize_s  in  3  AHB HSIZE (ignored; word access only)
hburst_s  in  3  AHB HBURST (ignored)
hresp_s  out  2  AHB HRESP
hready_s  out  1  AHB HREADYOUT
hsel_s  in  1  AHB HSEL
pwm  out  ch_n  PWM outputs
irq  out  1  period-wrap interrupt

Behaviour:
- Interface: one clock, hclk. Reset hreset is synchronous and active-high.
- Reset values: all registers and counters = 0; hrdata_s = 0; hresp_s = 2'b00; hready_s = 1; pwm = 0; irq = 0.
- AHB protocol: zero-wait-state. hready_s is held at 1 and hresp_s at OKAY.
- Address phase is accepted when hsel_s & htrans_s[1] & hready_s. On acceptance, haddr_s[7:2] and hwrite_s are latched.
- Write data commits at the end of the data phase.
- hrdata_s is driven combinationally from the latched address during the data phase. A read immediately following a write to the same register therefore returns the new value.
- Byte lanes and hsize_s are ignored; every write is a full word.
- Register map (byte offsets):
  - 0x00 CTRL: [0] en, [1] sync_upd, [2] irq_en
  - 0x04 PRESC: [pre_w-1:0]
  - 0x08 PERIOD: [pwm_w-1:0]
  - 0x0C STATUS: [0] wrap flag, write-1-to-clear
  - 0x10+4*i CMP[i] for i < ch_n
- Unmapped offsets read 0 and ignore writes. Unused upper bits read 0.
- Shadowing: PERIOD and CMP writes land in shadow registers. Shadows are copied to active registers:
  - immediately on the next cycle if en=0 or sync_upd=0;
  - otherwise only on a wrap event.
  - Readback always returns the shadow value.
- Prescaler: presc_cnt counts 0..PRESC. tick = en & (presc_cnt == PRESC), and presc_cnt returns to 0 on tick. PRESC=0 gives a tick every cycle.
- Period counter: cnt advances on tick. When cnt == PERIOD_active on a tick, cnt goes to 0 and a wrap event occurs; otherwise cnt increments by 1. The counter period is PERIOD+1 ticks.
- Disabled (en=0): presc_cnt=0, cnt=0, pwm=0, no wrap events.
- Output: pwm[i] registered, = en & (cnt < CMP_active[i]), with an unsigned pwm_w-bit compare.
  - CMP=0 → constant low.
  - CMP > PERIOD → constant high.
  - Duty = CMP/(PERIOD+1).
- Wrap flag: set on a wrap event. A W1C in the same cycle as a wrap leaves the flag set.
- irq = STATUS[0] & irq_en, registered.
- Period shrink: if PERIOD_active is written below the current cnt (immediate mode), the counter runs to its pwm_w-bit maximum, rolls over to 0, and produces no wrap event on the rollover.
- Reset mid-operation: all state returns to reset values on the next edge. Any in-flight AHB data phase is discarded.

Test Plan:
- Reset, then read all registers → every read returns 0, pwm=0, irq=0, hready_s=1, hresp_s=0.
- PRESC=0, PERIOD=9, CMP0=3, CTRL=1 → pwm[0] high 3 of every 10 cycles. STATUS[0] sets once per 10 cycles; W1C clears it.
- PRESC=3, PERIOD=4, CMP1=5 → pwm[1] constant high. CMP2=0 → pwm[2] constant low. STATUS sets every 20 cycles.
- sync_upd=1 with CMP0 changed mid-period from 3 to 7 → pwm[0] keeps the 3-tick duty until the wrap, then shows 7 ticks. Readback of CMP0 is 7 immediately.
- Back-to-back AHB: write PERIOD=0x55 then immediately read PERIOD → data phase returns 0x55. A read of offset 0xFC returns 0.
- irq_en=1, assert a wrap concurrent with a W1C to STATUS → flag stays 1 and irq stays 1. Assert hreset mid-period → pwm=0 and cnt=0 on the next edge.
